// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_v2: width derivation, parameter legality checks
// and the per-cycle operation encoding used by the occupancy logic.
package fifo_pkg;

  // Accepted operation this cycle, packed as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit af_ok(input int depth, input int af);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit ae_ok(input int depth, input int ae);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer-facing bundle of sync_fifo_v2. The FIFO uses the slave
// modport; the lane driving it (loader plus pipeline) uses master.
interface sync_fifo_v2_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic                  clr;
  logic                  wren;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  rden;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wren, i_data, rden,
    input  o_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  clr, wren, i_data, rden,
    output o_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// combinational read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_W    = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; empty/count gate every read, so stale contents
  // are never observed and the array can map onto plain enable flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised synchronous FIFO with optional first-word-fall-through output,
// occupancy count, almost-full/empty thresholds, sync clear and sticky errors.
module sync_fifo_v2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_v2_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_v2: DATA_WIDTH must be >= 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_v2: DEPTH must be a power of two and >= 2");
  end
  if (!af_ok(DEPTH, AF_THRESH)) begin : g_bad_af
    $error("sync_fifo_v2: AF_THRESH must lie in 1..DEPTH");
  end
  if (!ae_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
    $error("sync_fifo_v2: AE_THRESH must lie in 0..DEPTH-1");
  end

  // Pointers carry one extra bit and wrap modulo 2*DEPTH; only the low bits index.
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc, mem_we;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags decode from registered count only, so they change just after an edge.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_acc = bus.wren && (!full || bus.rden);
  assign rd_acc = bus.rden && !empty;
  assign op     = fifo_op_e'({wr_acc, rd_acc});
  assign mem_we = wr_acc && !bus.clr;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      case (op)
        OP_WR:   count_d = count_q + CNT_W'(1);
        OP_RD:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (wr_acc) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CNT_W'(1);
      // A simultaneous pop frees a slot, so a full FIFO with rden is not an overflow.
      overflow_d  = overflow_q  | (bus.wren && full && !bus.rden);
      underflow_d = underflow_q | (bus.rden && empty);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (bus.i_data),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Head of queue is visible directly; meaningless while empty.
    assign bus.o_data = mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (bus.clr)     rdata_d = '0;
      else if (rd_acc) rdata_d = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
    end

    assign bus.o_data = rdata_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: a standard-mode instance (AF=6, AE=2) driven
// from a vector table, and an FWFT instance driven by a hand-written sequence.
module tb_sync_fifo_v2;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_v2_if #(.DATA_WIDTH(8), .DEPTH(8)) if_std ();
  sync_fifo_v2_if #(.DATA_WIDTH(8), .DEPTH(8)) if_fwft ();

  sync_fifo_v2 #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .FWFT       (1'b0),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_std)
  );

  sync_fifo_v2 #(
    .DATA_WIDTH (8),
    .DEPTH      (8),
    .FWFT       (1'b1)
  ) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fwft)
  );

  typedef struct {
    logic       wren;
    logic       rden;
    logic       clr;
    logic [7:0] din;
    logic [3:0] cnt;
    logic       ovf;
    logic       unf;
    logic       chk_do;
    logic [7:0] dout;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic r, input logic c,
                              input logic [7:0] d, input int cnt,
                              input logic ovf, input logic unf,
                              input logic chk, input logic [7:0] dout);
    vec_t v;
    v.wren = w; v.rden = r; v.clr = c; v.din = d;
    v.cnt = 4'(cnt); v.ovf = ovf; v.unf = unf; v.chk_do = chk; v.dout = dout;
    vq.push_back(v);
  endfunction

  // Standard instance: flags follow directly from the expected count (AF=6, AE=2).
  task automatic check_std(input string tag, input vec_t v);
    check({tag, "_count"}, 32'(if_std.count), 32'(v.cnt));
    check({tag, "_empty"}, 32'(if_std.empty), 32'(v.cnt == 0));
    check({tag, "_full"},  32'(if_std.full),  32'(v.cnt == 8));
    check({tag, "_af"},    32'(if_std.almost_full),  32'(v.cnt >= 6));
    check({tag, "_ae"},    32'(if_std.almost_empty), 32'(v.cnt <= 2));
    check({tag, "_ovf"},   32'(if_std.overflow),  32'(v.ovf));
    check({tag, "_unf"},   32'(if_std.underflow), 32'(v.unf));
    if (v.chk_do) check({tag, "_odata"}, 32'(if_std.o_data), 32'(v.dout));
  endtask

  task automatic step_f(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    if_fwft.wren = w; if_fwft.rden = r; if_fwft.clr = c; if_fwft.i_data = d;
    @(posedge clk);
    #1;
    @(negedge clk);
    if_fwft.wren = 1'b0; if_fwft.rden = 1'b0; if_fwft.clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    if_std.wren  = 1'b0; if_std.rden  = 1'b0; if_std.clr  = 1'b0; if_std.i_data  = '0;
    if_fwft.wren = 1'b0; if_fwft.rden = 1'b0; if_fwft.clr = 1'b0; if_fwft.i_data = '0;

    // Basic write/read
    add(1, 0, 0, 8'h68, 1, 0, 0, 1, 8'h00);
    add(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h68);
    add(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h68);
    // Interleaved ordering
    add(1, 0, 0, 8'h45, 1, 0, 0, 1, 8'h68);
    add(1, 0, 0, 8'h35, 2, 0, 0, 1, 8'h68);
    add(1, 0, 0, 8'h25, 3, 0, 0, 1, 8'h68);
    add(0, 1, 0, 8'h00, 2, 0, 0, 1, 8'h45);
    add(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h35);
    add(1, 0, 0, 8'h65, 2, 0, 0, 1, 8'h35);
    add(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h25);
    add(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h65);
    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 8'(i), i, 0, 0, 1, 8'h65);
    add(1, 0, 0, 8'hFF, 8, 1, 0, 1, 8'h65);
    for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'h00, 8 - i, 1, 0, 1, 8'(i));
    add(0, 1, 0, 8'h00, 0, 1, 1, 1, 8'h08);
    add(0, 0, 1, 8'h00, 0, 0, 0, 1, 8'h00);
    // Full FIFO with simultaneous write+read across pointer wrap
    for (int i = 0; i < 8; i++) add(1, 0, 0, 8'(8'h10 + i), i + 1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 16; i++)
      add(1, 1, 0, 8'(8'h20 + i), 8, 0, 0, 1, (i < 8) ? 8'(8'h10 + i) : 8'(8'h20 + i - 8));
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'h00, 7 - i, 0, 0, 1, 8'(8'h28 + i));
    // Both requests while empty: write only, underflow, o_data held
    add(1, 1, 0, 8'h5A, 1, 0, 1, 1, 8'h2F);
    add(0, 1, 0, 8'h00, 0, 0, 1, 1, 8'h5A);
    // clr wins over a concurrent write
    add(1, 0, 1, 8'h77, 0, 0, 0, 1, 8'h00);
    add(0, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00);

    #12;
    check("rst_std_count", 32'(if_std.count), 32'd0);
    check("rst_std_empty", 32'(if_std.empty), 32'd1);
    check("rst_std_full",  32'(if_std.full),  32'd0);
    check("rst_std_af",    32'(if_std.almost_full),  32'd0);
    check("rst_std_ae",    32'(if_std.almost_empty), 32'd1);
    check("rst_std_ovf",   32'(if_std.overflow),  32'd0);
    check("rst_std_unf",   32'(if_std.underflow), 32'd0);
    check("rst_std_odata", 32'(if_std.o_data),    32'd0);
    check("rst_fwft_count", 32'(if_fwft.count), 32'd0);
    check("rst_fwft_empty", 32'(if_fwft.empty), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      if_std.wren = vq[i].wren; if_std.rden = vq[i].rden;
      if_std.clr  = vq[i].clr;  if_std.i_data = vq[i].din;
      @(posedge clk);
      #1;
      check_std($sformatf("v%0d", i), vq[i]);
    end
    @(negedge clk);
    if_std.wren = 1'b0; if_std.rden = 1'b0; if_std.clr = 1'b0;

    // FWFT sequence
    step_f(0, 1, 0, 8'h00);
    check("fwft_unf_set", 32'(if_fwft.underflow), 32'd1);
    check("fwft_unf_cnt", 32'(if_fwft.count), 32'd0);
    step_f(1, 0, 0, 8'hA5);
    check("fwft_a5_odata", 32'(if_fwft.o_data), 32'hA5);
    check("fwft_a5_empty", 32'(if_fwft.empty), 32'd0);
    check("fwft_a5_count", 32'(if_fwft.count), 32'd1);
    step_f(1, 0, 0, 8'hB6);
    step_f(1, 0, 0, 8'hC7);
    check("fwft_3_odata", 32'(if_fwft.o_data), 32'hA5);
    check("fwft_3_count", 32'(if_fwft.count), 32'd3);
    check("fwft_3_ae",    32'(if_fwft.almost_empty), 32'd0);
    step_f(0, 1, 0, 8'h00);
    check("fwft_pop_odata", 32'(if_fwft.o_data), 32'hB6);
    check("fwft_pop_count", 32'(if_fwft.count), 32'd2);
    step_f(1, 0, 0, 8'hD8);
    check("fwft_d8_count", 32'(if_fwft.count), 32'd3);
    check("fwft_d8_unf",   32'(if_fwft.underflow), 32'd1);
    step_f(0, 0, 1, 8'h00);
    check("fwft_clr_count", 32'(if_fwft.count), 32'd0);
    check("fwft_clr_empty", 32'(if_fwft.empty), 32'd1);
    check("fwft_clr_full",  32'(if_fwft.full),  32'd0);
    check("fwft_clr_af",    32'(if_fwft.almost_full),  32'd0);
    check("fwft_clr_ae",    32'(if_fwft.almost_empty), 32'd1);
    check("fwft_clr_ovf",   32'(if_fwft.overflow),  32'd0);
    check("fwft_clr_unf",   32'(if_fwft.underflow), 32'd0);
    step_f(1, 0, 0, 8'hE9);
    check("fwft_e9_odata", 32'(if_fwft.o_data), 32'hE9);
    check("fwft_e9_count", 32'(if_fwft.count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_v2.md
# sync_fifo_v2

Parametrised synchronous FIFO that replaces the single-mode 8x8 FIFO used at the input of the datapath. It adds configurable depth and width, a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, a synchronous clear, and sticky overflow/underflow error flags. It sits between the producer (host loader) and the consumer (compute pipeline), one instance per input lane.

## Interface
- DATA_WIDTH, 8: bits per word; must be ≥1.
- DEPTH, 8: number of entries; must be a power of two and ≥2.
- FWFT, 0: 0 selects standard mode (registered read, 1-cycle latency); 1 selects first-word-fall-through.
- AF_THRESH, DEPTH-1: almost_full asserts when count ≥ AF_THRESH; legal range is 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; legal range is 0..DEPTH-1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; empties the FIFO and clears the error flags.
- wren  in  1  write request.
- i_data  in  DATA_WIDTH  write data; sampled when wren is accepted.
- rden  in  1  read/pop request.
- o_data  out  DATA_WIDTH  read data (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a write attempted while full and not simultaneously accepted.
- underflow  out  1  sticky; set by a read attempted while empty.

## Operation
- Storage is a register array with DEPTH entries. The write and read pointers are $clog2(DEPTH)+1 bits wide and wrap naturally modulo 2·DEPTH; the index is the low $clog2(DEPTH) bits.
- Write accept: wren && (!full || rden).
- Read accept: rden && !empty.
- Case both requests, full: both are accepted, count is unchanged, no overflow.
- Case both requests, empty: only the write is accepted; underflow is set.
- Case wren while full without rden: write dropped, memory and pointers unchanged, overflow set.
- Case rden while empty: pointer unchanged, o_data unchanged, underflow set.
- count: +1 on write only, −1 on read only, unchanged on both or neither.
- Standard mode: o_data is registered and loads mem[rd_idx] on the clock edge that accepts a read. Otherwise it holds its last value.
- FWFT mode: o_data = mem[rd_idx] combinationally. It is valid whenever !empty; rden pops the current word. When empty, o_data is don't-care and the bench must not check it.
- clr has priority over wren/rden in the same cycle. It zeroes both pointers and count, clears overflow/underflow, and zeroes registered o_data. Memory contents are not cleared.
- Flags (full, empty, almost_*) are decoded combinationally from the registered count, so they are glitch-free relative to the clock edge.

## Timing
- Reset (async assert, sync-safe deassert by the top level): count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, o_data=0. Pointers are 0.
- Write-to-empty deassert: 1 cycle. Data written at edge N gives empty=0 after edge N.
- Standard-mode read latency: 1 cycle. A pop accepted at edge N presents data after edge N.
- FWFT: a word written at edge N is on o_data after edge N, with no extra cycle.
- Full and empty update on the same edge as count. Error flags set on the edge of the offending request.
- Back-to-back writes and reads at one per cycle are supported indefinitely, including across pointer wrap.

## Structure
- fifo_pkg holds the localparam helpers ADDR_W = $clog2(DEPTH) and CNT_W = ADDR_W+1, plus elaboration-time parameter checks: power-of-two DEPTH and threshold ranges, reported with $error.
- One sub-module, fifo_mem: a DEPTH×DATA_WIDTH register array with one synchronous write port and one combinational read port. sync_fifo_v2 holds pointers, count, flags and the mode-dependent o_data path.

## Test plan
- Reset, then write 0x68 and read in standard mode → o_data=0x68 one cycle after rden; empty toggles 1→0→1; count 0→1→0.
- Write 0x45, 0x35, 0x25 back-to-back; pop twice; write 0x65; pop twice → pops return 0x45, 0x35, 0x25, 0x65 in order; count peaks at 3.
- Write 8 words (0x01..0x08), then a 9th (0xFF) → full=1 and overflow=1 with count=8. Draining gives 0x01..0x08, 0xFF is absent, and an extra rden sets underflow.
- Full FIFO, wren+rden in the same cycle for 16 cycles → count stays 8, no overflow. Output is in-order across the pointer wrap.
- AF_THRESH=6, AE_THRESH=2: fill 0→8 then drain → almost_full asserts at count 6; almost_empty deasserts at count 3 and reasserts at count 2.
- FWFT=1: write 0xA5 → o_data=0xA5 the cycle after the write with no rden. Assert clr with 3 words held → next cycle count=0, empty=1, flags cleared.
